// File: rtl/mix_sat_pipe.sv
// Four-voice saturating mixer: per-voice mute/attenuate, full-precision sum, master gain, one saturation.
// Optional MIX_VOL_RAMP_EN slews the applied master gain by one step per output sample.

module mix_sat_voice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] i_ch,
    input  logic          i_mute,
    input  logic [2:0]    i_atten,
    output logic [SW+1:0] o_v
);

    logic signed [SW-1:0] w_shr;

    assign w_shr = $signed(i_ch) >>> i_atten;
    assign o_v   = i_mute ? '0 : {{2{w_shr[SW-1]}}, w_shr};

endmodule

module mix_sat_pipe #(
    parameter int SW     = 8,
    parameter int CLIP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [SW-1:0]     ch0,
    input  logic [SW-1:0]     ch1,
    input  logic [SW-1:0]     ch2,
    input  logic [SW-1:0]     ch3,
    input  logic [3:0]        mute,
    input  logic [11:0]       atten,
    input  logic [3:0]        master_vol,
    input  logic              clear_clip,
    output logic              out_valid,
    output logic [SW-1:0]     out_pcm,
    output logic [SW-1:0]     out_pwm,
    output logic              clip,
    output logic [CLIP_W-1:0] clip_count
);

    localparam int NUM_LANES = 4;
    localparam int PW        = SW + 7;

    localparam logic signed [PW-1:0] Q_MAX = {{8{1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [PW-1:0] Q_MIN = {{8{1'b1}}, {(SW-1){1'b0}}};
    localparam logic [SW-1:0]        PCM_MAX = {1'b0, {(SW-1){1'b1}}};
    localparam logic [SW-1:0]        PCM_MIN = {1'b1, {(SW-1){1'b0}}};

    logic [NUM_LANES-1:0][SW-1:0] w_ch;
    logic [NUM_LANES-1:0][SW+1:0] w_v;

    logic [2:0]                   r_vld;
    logic [NUM_LANES-1:0][SW+1:0] r_s1_v;
    logic [3:0]                   r_s1_vol;
    logic [SW+1:0]                r_s2_sum;
    logic [3:0]                   r_s2_vol;

    logic [SW+1:0]                w_sum;
    logic [3:0]                   w_vol_use;
    logic [4:0]                   w_gain;
    logic signed [PW-1:0]         w_sum_x;
    logic signed [PW-1:0]         w_gain_x;
    logic signed [PW-1:0]         w_p;
    logic signed [PW-1:0]         w_q;
    logic [SW-1:0]                w_sat;
    logic                         w_clip;

    logic [SW-1:0]                r_pcm;
    logic                         r_clip;
    logic [CLIP_W-1:0]            r_cnt;

    assign w_ch = {ch3, ch2, ch1, ch0};

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_voice
            mix_sat_voice #(.SW(SW)) u_voice (
                .i_ch    (w_ch[g]),
                .i_mute  (mute[g]),
                .i_atten (atten[3*g +: 3]),
                .o_v     (w_v[g])
            );
        end
    endgenerate

    // Valid travels alongside the data; reset empties every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[1:0], in_valid};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v   <= '0;
            r_s1_vol <= '0;
        end else if (in_valid) begin
            r_s1_v   <= w_v;
            r_s1_vol <= master_vol;
        end
    end

    // Four values in [-2^(SW-1), 2^(SW-1)-1] sum safely within SW+2 bits.
    assign w_sum = r_s1_v[0] + r_s1_v[1] + r_s1_v[2] + r_s1_v[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_sum <= '0;
            r_s2_vol <= '0;
        end else if (r_vld[0]) begin
            r_s2_sum <= w_sum;
            r_s2_vol <= r_s1_vol;
        end
    end

`ifdef MIX_VOL_RAMP_EN
    logic [3:0] r_vol_cur;

    // Applied gain walks one step per sample toward the requested volume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vol_cur <= 4'd15;
        end else if (r_vld[1]) begin
            if (r_vol_cur < r_s2_vol) begin
                r_vol_cur <= r_vol_cur + 4'd1;
            end else if (r_vol_cur > r_s2_vol) begin
                r_vol_cur <= r_vol_cur - 4'd1;
            end
        end
    end

    assign w_vol_use = r_vol_cur;
`else
    assign w_vol_use = r_s2_vol;
`endif

    assign w_gain   = {1'b0, w_vol_use} + 5'd1;
    assign w_sum_x  = {{5{r_s2_sum[SW+1]}}, r_s2_sum};
    assign w_gain_x = {{(SW+2){1'b0}}, w_gain};
    assign w_p      = w_sum_x * w_gain_x;
    assign w_q      = w_p >>> 4;

    always_comb begin
        w_sat  = w_q[SW-1:0];
        w_clip = 1'b0;
        if (w_q > Q_MAX) begin
            w_sat  = PCM_MAX;
            w_clip = 1'b1;
        end else if (w_q < Q_MIN) begin
            w_sat  = PCM_MIN;
            w_clip = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcm  <= '0;
            r_clip <= 1'b0;
        end else begin
            r_clip <= 1'b0;
            if (r_vld[1]) begin
                r_pcm  <= w_sat;
                r_clip <= w_clip;
            end
        end
    end

    // Clear takes priority over a coincident clip; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear_clip) begin
            r_cnt <= '0;
        end else if (r_vld[1] && w_clip && (r_cnt != {CLIP_W{1'b1}})) begin
            r_cnt <= r_cnt + CLIP_W'(1);
        end
    end

    assign out_valid  = r_vld[2];
    assign out_pcm    = r_pcm;
    assign out_pwm    = {~r_pcm[SW-1], r_pcm[SW-2:0]};
    assign clip       = r_clip;
    assign clip_count = r_cnt;

endmodule

// File: tb/tb_mix_sat_pipe.sv
// Scoreboard bench for mix_sat_pipe: expected samples queued at drive time, checked at out_valid.
module tb_mix_sat_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  ch0 = '0, ch1 = '0, ch2 = '0, ch3 = '0;
    logic [3:0]  mute = '0;
    logic [11:0] atten = '0;
    logic [3:0]  master_vol = 4'd15;
    logic        clear_clip = 1'b0;
    logic        out_valid;
    logic [7:0]  out_pcm, out_pwm;
    logic        clip;
    logic [15:0] clip_count;

    typedef struct {
        logic [7:0] pcm;
        logic       clip;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, n_out = 0;
    int   model_vol = 15;
    logic clr_q = 1'b0;
    logic [15:0] exp_cnt = '0;

    mix_sat_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
        .mute(mute), .atten(atten), .master_vol(master_vol),
        .clear_clip(clear_clip), .out_valid(out_valid),
        .out_pcm(out_pcm), .out_pwm(out_pwm), .clip(clip),
        .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0][7:0] c, input logic [3:0] m,
                                   input logic [11:0] at, input logic [3:0] v);
        exp_t e;
        int sum = 0, x, p, q, g;
        for (int i = 0; i < 4; i++) begin
            x = int'($signed(c[i]));
            if (!m[i]) sum += (x >>> at[3*i +: 3]);
        end
`ifdef MIX_VOL_RAMP_EN
        g = model_vol + 1;
        if (model_vol < int'(v)) model_vol++;
        else if (model_vol > int'(v)) model_vol--;
`else
        g = int'(v) + 1;
`endif
        p = sum * g;
        q = p >>> 4;
        e.clip = 1'b0;
        if (q > 127) begin e.pcm = 8'h7F; e.clip = 1'b1; end
        else if (q < -128) begin e.pcm = 8'h80; e.clip = 1'b1; end
        else e.pcm = 8'(q);
        e.cyc = 0;
        return e;
    endfunction

    task automatic send(input logic [7:0] a, b, c, d, input logic [3:0] m,
                        input logic [11:0] at, input logic [3:0] v);
        exp_t e;
        @(posedge clk); #1;
        ch0 = a; ch1 = b; ch2 = c; ch3 = d;
        mute = m; atten = at; master_vol = v; in_valid = 1'b1;
        e = model({d, c, b, a}, m, at, v);
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            t++;
        end
        chk("drain", sb.size(), 0);
    endtask

    always @(posedge clk) begin
        cyc++;
        clr_q = clear_clip;
    end

    always @(negedge clk) begin
        exp_t it;
        if (rst) begin
            exp_cnt = '0;
        end else if (out_valid) begin
            n_out++;
            if (sb.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                it = sb.pop_front();
                chk("pcm", out_pcm, it.pcm);
                chk("pwm", out_pwm, it.pcm ^ 8'h80);
                chk("clip", clip, it.clip);
                chk("latency", cyc - it.cyc, 3);
                if (clr_q) exp_cnt = '0;
                else if (it.clip && exp_cnt != 16'hFFFF) exp_cnt++;
                chk("clip_count", clip_count, exp_cnt);
            end
        end else begin
            if (clr_q) exp_cnt = '0;
            if (clip) chk("clip_idle", clip, 0);
        end
    end

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(10);
        chk("rst_pcm", out_pcm, 8'h00);
        chk("rst_pwm", out_pwm, 8'h80);
        chk("rst_cnt", clip_count, 0);
        chk("rst_no_valid", n_out, 0);

        send(8'd10, 8'd20, 8'd30, 8'd40, 4'b0000, 12'h000, 4'd15);
        idle(1);
        drain();

        for (int k = 0; k < 4; k++) send(8'h7F, 8'h7F, 8'h7F, 8'h7F, 4'b0000, 12'h000, 4'd15);
        idle(1);
        drain();
        chk("cnt_after_4", clip_count, 16'd4);

        send(8'h7F, 8'h7F, 8'h7F, 8'h7F, 4'b0000, 12'h000, 4'd15);
        idle(1);
        @(posedge clk); #1; clear_clip = 1'b1;
        @(posedge clk); #1; clear_clip = 1'b0;
        drain();
        chk("cnt_cleared", clip_count, 0);

        send(8'h80, 8'd55, 8'd66, 8'd77, 4'b1110, 12'h003, 4'd7);
        send(8'h80, 8'h80, 8'h80, 8'h80, 4'b0000, 12'h000, 4'd15);
        send(8'h81, 8'h81, 8'h81, 8'h81, 4'b0000, 12'h000, 4'd1);
        idle(1);
        drain();

        for (int k = 0; k < 24; k++) begin
            send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 4'($urandom), 12'($urandom), 4'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(1);
        drain();

`ifdef MIX_VOL_RAMP_EN
        for (int k = 0; k < 20; k++) send(8'd64, 8'd0, 8'd0, 8'd0, 4'b1110, 12'h000, 4'd0);
        idle(1);
        drain();
        chk("ramp_hold", out_pcm, 8'd4);
        for (int k = 0; k < 16; k++) send(8'd64, 8'd0, 8'd0, 8'd0, 4'b1110, 12'h000, 4'd15);
        idle(1);
        drain();
`endif

        seen = n_out;
        send(8'd1, 8'd2, 8'd3, 8'd4, 4'b0000, 12'h000, 4'd15);
        send(8'd5, 8'd6, 8'd7, 8'd8, 4'b0000, 12'h000, 4'd15);
        send(8'd9, 8'd10, 8'd11, 8'd12, 4'b0000, 12'h000, 4'd15);
        send(8'd13, 8'd14, 8'd15, 8'd16, 4'b0000, 12'h000, 4'd15);
        idle(1);
        @(posedge clk); #1;
        rst = 1'b1;
        chk("rst_flush_left", sb.size(), 2);
        sb.delete();
        model_vol = 15;
        @(posedge clk); #1;
        chk("rst_mid_pcm", out_pcm, 8'h00);
        chk("rst_mid_pwm", out_pwm, 8'h80);
        chk("rst_mid_cnt", clip_count, 0);
        rst = 1'b0;
        idle(8);
        chk("rst_mid_outs", n_out - seen, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mix_sat_pipe.md
Name: mix_sat_pipe

Overview:
Pipelined four-voice saturating mixer that sits between the four sample players and the PWM audio output stage. Each cycle that a sample strobe arrives, it:
- applies per-voice mute and attenuation,
- sums the voices at full precision,
- applies master volume,
- saturates once to 8-bit signed.
It also presents an offset-binary copy for the PWM duty input and counts clipping events for debug display.

Parameters:
- SW, 8, sample width (signed two's complement in, signed and offset-binary out)
- CLIP_W, 16, width of the saturating clip event counter

Ports:
- clk  in  1  system clock (hz2m domain)
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  one-cycle strobe; ch0..ch3 are sampled on this cycle
- ch0  in  SW  voice 0 sample, signed
- ch1  in  SW  voice 1 sample, signed
- ch2  in  SW  voice 2 sample, signed
- ch3  in  SW  voice 3 sample, signed
- mute  in  4  bit i forces voice i to 0
- atten  in  12  3 bits per voice ({ch3,ch2,ch1,ch0}); arithmetic right shift 0..7
- master_vol  in  4  gain = (master_vol+1)/16; 15 = unity
- clear_clip  in  1  synchronous clear of clip_count
- out_valid  out  1  one-cycle strobe, 3 cycles after in_valid
- out_pcm  out  SW  mixed sample, signed, saturated
- out_pwm  out  SW  out_pcm with MSB inverted (offset binary; 0x80 = silence)
- clip  out  1  pulses with out_valid when saturation occurred
- clip_count  out  CLIP_W  number of clipped outputs, saturating at all-ones

Behaviour:
- Reset: asynchronous, active-high.
  - All pipeline valids = 0, out_pcm = 0x00, out_pwm = 0x80, clip = 0, clip_count = 0.
  - Reset mid-operation discards all in-flight samples; no out_valid for inputs accepted before reset release.
- Pipeline is fully pipelined: it accepts in_valid every cycle, has no stall and no backpressure. Latency is exactly 3 clk cycles.
- Stage 1 (registered on in_valid):
  - v_i = mute[i] ? 0 : (ch_i >>> atten_i), sign-extended to SW+2 bits.
  - mute, atten and master_vol are sampled on this same cycle and carried down the pipe with the data.
- Stage 2:
  - sum = v0+v1+v2+v3 in SW+2 bits (10 bits at defaults). This cannot overflow.
- Stage 3:
  - p = sum * (master_vol+1), signed, SW+7 bits; q = p >>> 4 (arithmetic).
  - If q > 127 then out_pcm = 0x7F; if q < -128 then out_pcm = 0x80; otherwise out_pcm = q[7:0].
  - clip = 1 in the same cycle as out_valid when either limit was applied.
- out_pcm, out_pwm and clip_count update only on out_valid cycles and hold otherwise. clip is 0 whenever out_valid is 0.
- clip_count:
  - Increments on each clip pulse and saturates at 2^CLIP_W-1 (no wrap).
  - If clear_clip and clip occur in the same cycle, clear wins and the count becomes 0.
- Back-to-back in_valid on consecutive cycles produces back-to-back out_valid with independent results. Gaps in in_valid are preserved at the output.
- All four voices at -128 with unity gain: sum = -512, q = -512, so out_pcm = 0x80 and clip = 1.
- No internal state persists between samples except clip_count (and the ramp register when the optional feature is enabled).

Optional Feature:
MIX_VOL_RAMP_EN
- Defined:
  - An internal vol_cur register (reset value 15) is used in place of the sampled master_vol in stage 3.
  - On each out_valid, vol_cur moves 1 step toward the master_vol value that was sampled with that sample, and never overshoots.
  - This suppresses zipper noise on volume changes. Worst case: 15 samples to settle.
- Not defined: master_vol is applied directly per sample, exactly as described in Behaviour.

Test Plan:
- Reset release with in_valid idle -> out_pwm = 0x80, out_pcm = 0x00, clip_count = 0, no out_valid for 10 cycles.
- ch = {10,20,30,40}, atten = 0, mute = 0, master_vol = 15, in_valid at cycle t -> out_valid at t+3, out_pcm = 100 (0x64), out_pwm = 0xE4, clip = 0.
- ch = all 0x7F, master_vol = 15 -> out_pcm = 0x7F, clip = 1, clip_count = 1. Repeat 3 more times -> clip_count = 4. Then assert clear_clip in the same cycle as a clipping out_valid -> clip_count = 0.
- ch0 = -128, atten0 = 3, others muted, master_vol = 7 -> v0 = -16, q = -16*8/16 = -8, out_pcm = 0xF8.
- in_valid on 4 consecutive cycles with distinct data, then assert rst on the cycle after the 2nd out_valid -> exactly 2 out_valids observed with correct values, outputs return to reset values, no further out_valid.
- With MIX_VOL_RAMP_EN defined: constant ch0 = 64 on voice 0 only, master_vol changes 15 -> 0 -> out_pcm steps 64, 60, 56, … and reaches 4 after 15 samples, then holds at 4.
